// File: rtl/processor_controller.sv
// processor_controller: timestep sequencer and decoder for the 10-bit processor.
// Optional build macro CTRL_ILLEGAL_TRAP_EN turns illegal opcodes into a sticky trap.
module processor_controller (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       run,
    input  logic [9:0] instr_in,
    output logic       ext_out,
    output logic       imm_out,
    output logic [9:0] imm_value,
    output logic [3:0] rin,
    output logic [3:0] rout,
    output logic       a_load,
    output logic       g_load,
    output logic       g_out,
    output logic [3:0] alu_fn,
    output logic       done,
    output logic [1:0] timestep,
    output logic       illegal
);
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    tstep_t     r_t;
    logic [9:0] r_ir;

    logic [1:0] w_cls;
    logic [1:0] w_x;
    logic [1:0] w_y;
    logic [3:0] w_op;
    logic [3:0] w_rx;
    logic [3:0] w_ry;
    logic       w_ill;
    logic       w_imm;
    logic       w_ld;
    logic       w_cp;
    logic       w_alu1;
    logic [1:0] w_len;
    logic       w_last;
    logic       w_halt;
    logic       w_ill_done;

    assign w_cls = r_ir[9:8];
    assign w_x   = r_ir[7:6];
    assign w_y   = r_ir[5:4];
    assign w_op  = r_ir[3:0];
    assign w_rx  = 4'b0001 << w_x;
    assign w_ry  = 4'b0001 << w_y;

    assign w_ill  = (w_cls == 2'b01)
                 || (w_cls == 2'b00 && w_op[3:2] == 2'b11);
    assign w_imm  = w_cls[1];
    assign w_ld   = (w_cls == 2'b00) && (w_op == 4'd0);
    assign w_cp   = (w_cls == 2'b00) && (w_op == 4'd1);
    assign w_alu1 = (w_cls == 2'b00)
                 && (w_op == 4'd4 || w_op == 4'd5);

    // Number of execute steps after T0; the last one is the done step.
    always_comb begin
        w_len = 2'd3;
        if (w_ill || w_ld || w_cp)
            w_len = 2'd1;
        else if (w_alu1)
            w_len = 2'd2;
    end

    assign w_last    = (r_t != T0) && (r_t == tstep_t'(w_len));
    assign timestep  = r_t;
    assign imm_value = {4'b0000, r_ir[5:0]};

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)
            r_trap <= 1'b0;
        else if (r_t == T1 && w_ill)
            r_trap <= 1'b1;
    end

    assign w_halt     = r_trap;
    assign w_ill_done = 1'b0;
    assign illegal    = r_trap | (r_t == T1 && w_ill);
`else
    assign w_halt     = 1'b0;
    assign w_ill_done = 1'b1;
    assign illegal    = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_t  <= T0;
            r_ir <= '0;
        end else begin
            unique case (r_t)
                T0: begin
                    if (run && !w_halt) begin
                        r_ir <= instr_in;
                        r_t  <= T1;
                    end
                end
                default: begin
                    if (w_last)
                        r_t <= T0;
                    else
                        r_t <= tstep_t'(r_t + 2'd1);
                end
            endcase
        end
    end

    always_comb begin
        ext_out = 1'b0;
        imm_out = 1'b0;
        rin     = '0;
        rout    = '0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        g_out   = 1'b0;
        alu_fn  = '0;
        done    = 1'b0;
        if (w_last) begin
            if (w_ill) begin
                done = w_ill_done;
            end else if (w_ld) begin
                ext_out = 1'b1;
                rin     = w_rx;
                done    = 1'b1;
            end else if (w_cp) begin
                rout = w_ry;
                rin  = w_rx;
                done = 1'b1;
            end else begin
                g_out = 1'b1;
                rin   = w_rx;
                done  = 1'b1;
            end
        end else if (r_t == T1) begin
            if (w_alu1) begin
                rout   = w_ry;
                g_load = 1'b1;
                alu_fn = w_op;
            end else begin
                rout   = w_rx;
                a_load = 1'b1;
            end
        end else if (r_t == T2) begin
            g_load = 1'b1;
            // Immediate class: class bit 0 picks sub (0011) over add (0010).
            if (w_imm) begin
                imm_out = 1'b1;
                alu_fn  = {3'b001, w_cls[0]};
            end else begin
                rout   = w_ry;
                alu_fn = w_op;
            end
        end
    end
endmodule

// File: tb/tb_processor_controller.sv
// Bench for processor_controller: per-instruction output schedule model,
// per-cycle compare, plus directed literal checks.
`timescale 1ns/1ps
module tb_processor_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [9:0] instr_in = '0;
    logic       ext_out, imm_out, a_load, g_load, g_out, done, illegal;
    logic [9:0] imm_value;
    logic [3:0] rin, rout, alu_fn;
    logic [1:0] timestep;

    always #5 clk = ~clk;

    processor_controller dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .run       (run),
        .instr_in  (instr_in),
        .ext_out   (ext_out),
        .imm_out   (imm_out),
        .imm_value (imm_value),
        .rin       (rin),
        .rout      (rout),
        .a_load    (a_load),
        .g_load    (g_load),
        .g_out     (g_out),
        .alu_fn    (alu_fn),
        .done      (done),
        .timestep  (timestep),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic       ext;
        logic       imm;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       a;
        logic       g;
        logic       go;
        logic [3:0] fn;
        logic       done;
        logic [1:0] ts;
        logic       ill;
    } ov_t;

    ov_t        q[$];
    logic [9:0] m_ir = '0;
    logic       m_trap = 1'b0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic ov_t mk(
        input logic ext, input logic imm,
        input logic [3:0] ri, input logic [3:0] ro,
        input logic a, input logic g, input logic go,
        input logic [3:0] fn, input logic dn,
        input logic [1:0] ts, input logic il);
        ov_t v;
        v = '{ext, imm, ri, ro, a, g, go, fn, dn, ts, il};
        return v;
    endfunction

    // Whole-instruction output schedule, one entry per cycle after T0.
    task automatic push_seq(input logic [9:0] ir);
        logic [1:0] c;
        logic [3:0] x, y, op;
        c  = ir[9:8];
        x  = 4'b0001 << ir[7:6];
        y  = 4'b0001 << ir[5:4];
        op = ir[3:0];
        if (c == 2'd1 || (c == 2'd0 && op >= 4'd12)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
`else
            q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`endif
        end else if (c >= 2'd2) begin
            q.push_back(mk(0, 0, 0, x, 1, 0, 0, 0, 0, 1, 0));
            q.push_back(mk(0, 1, 0, 0, 0, 1, 0,
                           (c == 2'd3) ? 4'd3 : 4'd2, 0, 2, 0));
            q.push_back(mk(0, 0, x, 0, 0, 0, 1, 0, 1, 3, 0));
        end else if (op == 4'd0) begin
            q.push_back(mk(1, 0, x, 0, 0, 0, 0, 0, 1, 1, 0));
        end else if (op == 4'd1) begin
            q.push_back(mk(0, 0, x, y, 0, 0, 0, 0, 1, 1, 0));
        end else if (op == 4'd4 || op == 4'd5) begin
            q.push_back(mk(0, 0, 0, y, 0, 1, 0, op, 0, 1, 0));
            q.push_back(mk(0, 0, x, 0, 0, 0, 1, 0, 1, 2, 0));
        end else begin
            q.push_back(mk(0, 0, 0, x, 1, 0, 0, 0, 0, 1, 0));
            q.push_back(mk(0, 0, 0, y, 0, 1, 0, op, 0, 2, 0));
            q.push_back(mk(0, 0, x, 0, 0, 0, 1, 0, 1, 3, 0));
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ir   = '0;
            m_trap = 1'b0;
        end else if (q.size() > 0) begin
            if (q[0].ill)
                m_trap = 1'b1;
            void'(q.pop_front());
        end else if (run && !m_trap) begin
            m_ir = instr_in;
            push_seq(instr_in);
        end
    end

    always @(negedge clk) begin
        ov_t e;
        ov_t a;
        e = (q.size() > 0) ? q[0] : '0;
        if (m_trap)
            e.ill = 1'b1;
        a = {ext_out, imm_out, rin, rout, a_load, g_load, g_out,
             alu_fn, done, timestep, illegal};
        chk("cycle_outputs", 32'(a), 32'(e));
        chk("imm_value", 32'(imm_value), {22'd0, 4'b0000, m_ir[5:0]});
        chk("bus_exclusive",
            32'(($countones({ext_out, imm_out, g_out, |rout}) <= 1)
                && ($countones(rin) <= 1)
                && ($countones(rout) <= 1)), 32'd1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [9:0] ir);
        run      = 1'b1;
        instr_in = ir;
        tick();
        run      = 1'b0;
        instr_in = 10'($urandom);
    endtask

    task automatic idle();
        int n;
        n = 0;
        while (timestep != 2'd0 && n < 8) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(timestep), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("reset_outs",
            32'({ext_out, imm_out, rin, rout, a_load, g_load, g_out,
                 alu_fn, done, timestep, illegal, imm_value}), 32'd0);
        rst = 1'b0;
        tick();

        issue(10'b00_10_00_0000);
        chk("ld_ext", 32'(ext_out), 32'd1);
        chk("ld_rin", 32'(rin), 32'b0100);
        chk("ld_done", 32'(done), 32'd1);
        tick();
        chk("ld_back_t0", 32'({timestep, done, rin, ext_out}), 32'd0);

        issue(10'b00_01_11_0010);
        chk("add_t1", 32'({rout, a_load}), 32'b0010_1);
        tick();
        chk("add_t2", 32'({rout, g_load, alu_fn}), 32'b1000_1_0010);
        tick();
        chk("add_t3", 32'({g_out, rin, done}), 32'b1_0010_1);
        tick();

        issue(10'b00_00_10_0101);
        chk("flp_t1", 32'({rout, g_load, alu_fn, a_load}),
            32'b0100_1_0101_0);
        tick();
        chk("flp_t2", 32'({g_out, rin, done}), 32'b1_0001_1);
        tick();

        issue(10'b11_11_101101);
        tick();
        chk("subi_t2", 32'({imm_out, imm_value, alu_fn}),
            32'b1_0000101101_0011);
        tick();
        chk("subi_done", 32'({done, timestep}), 32'b1_11);
        tick();

        for (int op = 2; op < 12; op++) begin
            issue({2'b00, 2'(op % 4), 2'(3 - op % 4), 4'(op)});
            idle();
        end
        issue(10'b10_01_000111);
        idle();
        issue(10'b00_11_00_0001);
        chk("cp_t1", 32'({rout, rin, done}), 32'b0001_1000_1);
        idle();

        run      = 1'b1;
        instr_in = 10'b00_10_00_0010;
        tick();
        instr_in = 10'b00_00_01_0001;
        chk("b2b_a_t1", 32'(rout), 32'b0100);
        tick(2);
        chk("b2b_a_done", 32'({rin, done}), 32'b0100_1);
        tick();
        chk("b2b_gap_t0", 32'(timestep), 32'd0);
        tick();
        run = 1'b0;
        chk("b2b_second", 32'({rout, rin, done}), 32'b0010_0001_1);
        tick();

        issue(10'b00_01_11_0010);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_async",
            32'({ext_out, imm_out, rin, rout, a_load, g_load, g_out,
                 alu_fn, done, timestep}), 32'd0);
        tick();
        rst = 1'b0;
        tick(3);
        chk("rst_no_rin", 32'(rin), 32'd0);

        issue(10'b00_00_00_1111);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("trap_flag", 32'(illegal), 32'd1);
        chk("trap_no_done", 32'(done), 32'd0);
        tick();
        run      = 1'b1;
        instr_in = 10'b00_01_00_0000;
        tick(3);
        chk("trap_ignores_run", 32'(timestep), 32'd0);
        chk("trap_sticky", 32'(illegal), 32'd1);
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("trap_cleared", 32'(illegal), 32'd0);
        issue(10'b00_01_00_0000);
        chk("trap_after_rst", 32'({ext_out, rin}), 32'b1_0010);
        tick();
`else
        chk("ill_done", 32'({done, illegal}), 32'b1_0);
        tick();
        issue(10'b00_01_00_0000);
        chk("after_ill_ld", 32'({ext_out, rin}), 32'b1_0010);
        tick();
        issue(10'b01_00_00_0010);
        chk("cls01_nop", 32'({done, rout, a_load}), 32'b1_0000_0);
        tick();
`endif
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
